// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
// Pairs with the receiver; UART_TX_PARITY_EN selects 8E1 framing.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  localparam int UART_CLKS_PER_BIT_DEFAULT = 868;
  localparam int UART_DATA_BITS = 8;

  function automatic logic even_parity(
    input logic [UART_DATA_BITS-1:0] d
  );
    return ^d;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO feeding the UART transmitter.
// Full/empty come from the occupancy count; pointers wrap naturally.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic [UART_DATA_BITS-1:0]   din,
  input  logic                        pop,
  output logic [UART_DATA_BITS-1:0]   dout,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(DEPTH):0]      count
);

  localparam int AW = $clog2(DEPTH);

  logic [UART_DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]             wr_ptr;
  logic [AW-1:0]             rd_ptr;
  logic                      do_push;
  logic                      do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  // A full FIFO refuses the push even when a pop frees a slot this cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_byte_tx.sv
// Buffered 8N1 UART transmitter: valid/ready byte intake, FIFO, serialiser.
// Define UART_TX_PARITY_EN for an even parity bit (8E1 framing).
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          uart_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  uart_tx_state_t            state;
  uart_tx_state_t            state_d;
  logic [BW-1:0]             baud;
  logic [BW-1:0]             baud_d;
  logic [2:0]                bit_cnt;
  logic [2:0]                bit_d;
  logic [UART_DATA_BITS-1:0] shreg;
  logic [UART_DATA_BITS-1:0] shreg_d;
  logic                      tx_d;
  logic                      bit_done;
  logic                      load;
  logic                      pop;
  logic                      full;
  logic                      empty;
  logic [UART_DATA_BITS-1:0] fifo_dout;
`ifdef UART_TX_PARITY_EN
  logic                      par;
  logic                      par_d;
`endif

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_valid),
    .din   (tx_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  assign tx_ready = !full;
  assign busy     = (state != IDLE) || !empty;
  assign bit_done = (baud == BAUD_LAST);

  always_comb begin
    state_d = state;
    baud_d  = baud;
    bit_d   = bit_cnt;
    shreg_d = shreg;
    tx_d    = uart_tx;
    load    = 1'b0;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par;
`endif
    if (state != IDLE) baud_d = bit_done ? '0 : baud + 1'b1;

    unique case (state)
      IDLE: begin
        tx_d = 1'b1;
        if (!empty) load = 1'b1;
      end
      START: begin
        if (bit_done) begin
          tx_d    = shreg[0];
          shreg_d = shreg >> 1;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = par;
            state_d = PARITY;
`else
            tx_d    = 1'b1;
            state_d = STOP;
`endif
          end else begin
            tx_d    = shreg[0];
            shreg_d = shreg >> 1;
            bit_d   = bit_cnt + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          tx_d    = 1'b1;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_done) begin
          // Chain straight into the next start bit: no idle gap.
          if (!empty) load = 1'b1;
          else        state_d = IDLE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase

    if (load) begin
      pop     = 1'b1;
      shreg_d = fifo_dout;
      tx_d    = 1'b0;
      bit_d   = '0;
      baud_d  = '0;
      state_d = START;
`ifdef UART_TX_PARITY_EN
      par_d   = even_parity(fifo_dout);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      uart_tx <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state   <= state_d;
      baud    <= baud_d;
      bit_cnt <= bit_d;
      shreg   <= shreg_d;
      uart_tx <= tx_d;
`ifdef UART_TX_PARITY_EN
      par     <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Directed + randomized bench for uart_byte_tx (CLKS_PER_BIT=4, depth 4).
// A line monitor checks every frame sample against a byte scoreboard.
module tb_uart_byte_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FBITS = 11;
`else
  localparam int FBITS = 10;
`endif
  localparam int FCYC = FBITS * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       uart_tx;
  logic       busy;
  logic [2:0] fifo_count;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] sb[$];
  int         gap_q[$];
  int         frames = 0;
  bit         mon_en = 1'b0;

  always #5 clk = ~clk;

  uart_byte_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .uart_tx    (uart_tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line level of frame bit k for byte b: start, 8 data LSB first,
  // optional even parity, stop.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return logic'((b >> (k - 1)) & 8'd1);
    if (FBITS == 11 && k == 9) return logic'($countones(b) % 2);
    return 1'b1;
  endfunction

  initial begin : monitor
    int idle;
    logic [7:0] b;
    bit aborted;
    idle = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) idle = 0;
      else if (uart_tx === 1'b1) idle++;
      else begin
        gap_q.push_back(idle);
        idle = 0;
        if (sb.size() == 0) begin
          check("unexpected_start", uart_tx, 1);
          repeat (FCYC - 1) @(negedge clk);
        end else begin
          b = sb.pop_front();
          aborted = 1'b0;
          for (int i = 0; i < FCYC; i++) begin
            if (i != 0) @(negedge clk);
            if (!mon_en) begin
              aborted = 1'b1;
              break;
            end
            check("frame_bit", uart_tx, frame_bit(b, i / CPB));
          end
          if (!aborted) frames++;
        end
      end
    end
  end

  task automatic push_byte(input logic [7:0] b);
    int w;
    w = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("push_ready", tx_ready, 1);
    sb.push_back(b);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while ((busy !== 1'b0 || uart_tx !== 1'b1) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    check("drain_busy", busy, 0);
    check("drain_sb", sb.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int f0;
    int w;
    logic [7:0] b;
    logic [7:0] r [4];

    repeat (3) @(negedge clk);
    check("rst_line", uart_tx, 1);
    check("rst_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_count", fifo_count, 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    check("idle_line", uart_tx, 1);

    // Single 0x55: latency, frame, busy release.
    f0 = frames;
    push_byte(8'h55);
    check("lat_line_n0", uart_tx, 1);
    check("lat_count_n0", fifo_count, 1);
    check("lat_busy_n0", busy, 1);
    @(negedge clk);
    check("lat_line_n1", uart_tx, 0);
    repeat (FCYC - 1) @(negedge clk);
    check("busy_stop", busy, 1);
    @(negedge clk);
    check("busy_fall", busy, 0);
    check("line_idle", uart_tx, 1);
    check("single_frames", frames - f0, 1);
    repeat (4) @(negedge clk);

    // Three back-to-back frames.
    gap_q.delete();
    f0 = frames;
    push_byte(8'hA5);
    push_byte(8'h3C);
    push_byte(8'hFF);
    repeat (3 * FCYC - 2) @(negedge clk);
    check("b2b_busy_end", busy, 1);
    @(negedge clk);
    check("b2b_busy_fall", busy, 0);
    check("b2b_frames", frames - f0, 3);
    check("b2b_starts", gap_q.size(), 3);
    if (gap_q.size() == 3) begin
      check("b2b_gap1", gap_q[1], 0);
      check("b2b_gap2", gap_q[2], 0);
    end
    wait_idle();

    // Hold tx_valid for 6 bytes while the first frame is in flight.
    f0 = frames;
    tx_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      tx_data = b;
      w = 0;
      while (tx_ready !== 1'b1 && w < 100) begin
        if (w == 0) begin
          check("hold_count_full", fifo_count, DEPTH);
          check("hold_accepted", i, 5);
        end
        tx_data = ~b;
        @(negedge clk);
        w++;
      end
      tx_data = b;
      if (i == 5) check("hold_stall_cycles", w, FCYC - 3);
      sb.push_back(b);
      @(negedge clk);
    end
    tx_valid = 1'b0;
    wait_idle();
    check("hold_frames", frames - f0, 6);

    // Push and pop on the same edge with two bytes queued.
    for (int i = 0; i < 4; i++) r[i] = 8'($urandom);
    push_byte(r[0]);
    push_byte(r[1]);
    push_byte(r[2]);
    repeat (FCYC - 2) @(negedge clk);
    check("pp_count_before", fifo_count, 2);
    tx_data  = r[3];
    tx_valid = 1'b1;
    sb.push_back(r[3]);
    @(negedge clk);
    tx_valid = 1'b0;
    check("pp_count_after", fifo_count, 2);
    wait_idle();

`ifdef UART_TX_PARITY_EN
    push_byte(8'h07);
    repeat (37) @(negedge clk);
    check("parity_07", uart_tx, 1);
    wait_idle();
    push_byte(8'h03);
    repeat (37) @(negedge clk);
    check("parity_03", uart_tx, 0);
    wait_idle();
`endif

    // Reset in the middle of bit 3 of 0x0F with two bytes queued.
    push_byte(8'h0F);
    push_byte(8'($urandom));
    push_byte(8'($urandom));
    check("rstmid_count_before", fifo_count, 2);
    repeat (16) @(negedge clk);
    mon_en = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("rstmid_line", uart_tx, 1);
    check("rstmid_count", fifo_count, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_ready", tx_ready, 1);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2 * FCYC; i++) begin
      @(negedge clk);
      check("rstmid_idle_line", uart_tx, 1);
    end
    check("rstmid_idle_busy", busy, 0);
    mon_en = 1'b1;

    // Randomized bytes with random spacing.
    f0 = frames;
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 50)) @(negedge clk);
      push_byte(8'($urandom));
    end
    wait_idle();
    check("rand_frames", frames - f0, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
